// File: rtl/des_mem_sequencer.sv
// des_mem_sequencer: walks a block range through an external DES core.
// For each block: read src_base+count from port 0, offer it to the core, wait
// for the result, write it to dst_base+count on port 1. Addresses wrap mod 2^ADDR_W.
// Ports:
//   clk, rst (async, active-low)
//   start/src_base/dst_base/num_blocks : job request; busy/done : job status
//   mem_en, rd_wr/rd_add/rd_data : port 0 (read only, rd_data one cycle late)
//   wr_wr/wr_add/wr_data         : port 1 (wr_wr active-low write strobe)
//   core_in_*  : block handshake to the core; core_out_* : result pulse back
module des_mem_sequencer #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   num_blocks,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_wr,
  output logic [ADDR_W-1:0] wr_add,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_data
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StSend, StWaitRes, StWrite, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   blk_q, blk_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [ADDR_W:0]     cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    blk_d         = blk_q;
    res_d         = res_q;
    busy          = 1'b1;
    done          = 1'b0;
    mem_en        = 1'b0;
    rd_wr         = 1'b1;
    rd_add        = '0;
    wr_wr         = 1'b1;
    wr_add        = '0;
    wr_data       = '0;
    core_in_valid = 1'b0;
    core_in_data  = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          num_d   = num_blocks;
          cnt_d   = '0;
          state_d = (num_blocks == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        mem_en  = 1'b1;
        rd_add  = src_q + cnt_q[ADDR_W-1:0];
        state_d = StRdWait;
      end
      StRdWait: begin
        // Address stays up so the read port sees a steady request.
        mem_en  = 1'b1;
        rd_add  = src_q + cnt_q[ADDR_W-1:0];
        blk_d   = rd_data;
        state_d = StSend;
      end
      StSend: begin
        core_in_valid = 1'b1;
        core_in_data  = blk_q;
        if (core_in_ready) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (core_out_valid) begin
          res_d   = core_out_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_en  = 1'b1;
        wr_wr   = 1'b0;
        wr_add  = dst_q + cnt_q[ADDR_W-1:0];
        wr_data = res_q;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == num_q) ? StDone : StRdReq;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_des_mem_sequencer.sv
module tb_des_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  src_base = '0;
  logic [5:0]  dst_base = '0;
  logic [6:0]  num_blocks = '0;
  logic        busy, done, mem_en, rd_wr, wr_wr, core_in_valid;
  logic [5:0]  rd_add, wr_add;
  logic [63:0] rd_data = '0;
  logic [63:0] wr_data, core_in_data;
  logic        core_in_ready;
  logic        core_out_valid = 1'b0;
  logic [63:0] core_out_data = '0;

  always #5 clk = ~clk;

  des_mem_sequencer #(.ADDR_W(6), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .num_blocks(num_blocks), .busy(busy), .done(done), .mem_en(mem_en), .rd_wr(rd_wr),
    .rd_add(rd_add), .rd_data(rd_data), .wr_wr(wr_wr), .wr_add(wr_add), .wr_data(wr_data),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data), .core_out_valid(core_out_valid),
    .core_out_data(core_out_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in core: the known DES vector maps to its ciphertext, anything else
  // goes through a simple invertible scramble.
  function automatic logic [63:0] core_fn(input logic [63:0] x);
    if (x == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
    return {x[31:0], x[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  // Memory model with a host load port and access logs.
  logic [63:0] mem [64];
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [63:0] host_data = '0;
  logic [5:0]  wr_addr_log [256];
  logic [63:0] wr_data_log [256];
  logic [5:0]  rd_log [256];
  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, men_cnt = 0;
  logic        prev_rd = 1'b0;

  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    if (mem_en && wr_wr) rd_data <= mem[rd_add];
    if (mem_en && !wr_wr) begin
      mem[wr_add]         <= wr_data;
      wr_addr_log[wr_cnt] <= wr_add;
      wr_data_log[wr_cnt] <= wr_data;
      wr_cnt              <= wr_cnt + 1;
    end
    if (mem_en && wr_wr && !prev_rd) begin
      rd_log[rd_cnt] <= rd_add;
      rd_cnt         <= rd_cnt + 1;
    end
    prev_rd <= mem_en && wr_wr;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_en) men_cnt <= men_cnt + 1;
  end

  // Core model with programmable latency and ready gating.
  logic        ready_en = 1'b1;
  int          core_lat = 2;
  int          pend_cnt = 0;
  int          acc_cnt = 0;
  logic [63:0] pend_data = '0;
  assign core_in_ready = ready_en;

  always @(posedge clk) begin
    core_out_valid <= 1'b0;
    if (pend_cnt != 0) begin
      if (pend_cnt == 1) begin
        core_out_valid <= 1'b1;
        core_out_data  <= core_fn(pend_data);
      end
      pend_cnt <= pend_cnt - 1;
    end else if (core_in_valid && core_in_ready) begin
      pend_data <= core_in_data;
      pend_cnt  <= core_lat;
      acc_cnt   <= acc_cnt + 1;
    end
  end

  task automatic mem_load(input logic [5:0] a, input logic [63:0] d);
    host_addr = a;
    host_data = d;
    host_we   = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] s, input logic [5:0] d, input logic [6:0] n);
    src_base   = s;
    dst_base   = d;
    num_blocks = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    bit seen = 0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      cycles++;
      @(negedge clk);
    end
    if (!seen) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_rd_wr"}, rd_wr, 1);
    check_eq({tag, "_wr_wr"}, wr_wr, 1);
    check_eq({tag, "_civ"}, core_in_valid, 0);
    check_eq({tag, "_rd_add"}, rd_add, 0);
    check_eq({tag, "_wr_add"}, wr_add, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_cin_data"}, core_in_data, 0);
  endtask

  initial begin
    int wb, db, rb, mb, ab, cyc;
    logic [63:0] held;
    logic [5:0]  exp_addr [4];
    logic [63:0] wv [4];
    bit          ok;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Single block, known DES vector
    mem_load(6'd0, 64'h0123456789ABCDEF);
    wb = wr_cnt; db = done_cnt;
    pulse_start(6'd0, 6'd32, 7'd1);
    wait_done("single", 50, cyc);
    check_eq("single_nwr", wr_cnt - wb, 1);
    check_eq("single_addr", wr_addr_log[wb], 6'd32);
    check_eq("single_data", wr_data_log[wb], 64'h85E813540F0AB405);
    check_eq("single_ndone", done_cnt - db, 1);
    check_eq("single_busy", busy, 0);

    // Wrap, in place
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0; exp_addr[3] = 6'd1;
    wv[0] = 64'h1111_2222_3333_4444; wv[1] = 64'hDEAD_BEEF_0000_FFFF;
    wv[2] = 64'h0F1E_2D3C_4B5A_6978; wv[3] = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 4; i++) mem_load(exp_addr[i], wv[i]);
    wb = wr_cnt; rb = rd_cnt;
    pulse_start(6'd62, 6'd62, 7'd4);
    wait_done("wrap", 200, cyc);
    check_eq("wrap_nwr", wr_cnt - wb, 4);
    check_eq("wrap_nrd", rd_cnt - rb, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wrap_rd%0d", i), rd_log[rb + i], exp_addr[i]);
      check_eq($sformatf("wrap_wa%0d", i), wr_addr_log[wb + i], exp_addr[i]);
      check_eq($sformatf("wrap_wd%0d", i), wr_data_log[wb + i], core_fn(wv[i]));
    end

    // Backpressure: ready low for 10 cycles
    mem_load(6'd5, 64'hCAFE_F00D_1234_5678);
    ready_en = 1'b0;
    wb = wr_cnt;
    pulse_start(6'd5, 6'd10, 7'd1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_in_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("bp_valid_seen", ok, 1);
    held = core_in_data;
    check_eq("bp_data", held, 64'hCAFE_F00D_1234_5678);
    mb = men_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_valid%0d", i), core_in_valid, 1);
      check_eq($sformatf("bp_hold%0d", i), core_in_data, held);
    end
    check_eq("bp_no_mem", men_cnt - mb, 0);
    ready_en = 1'b1;
    wait_done("bp", 50, cyc);
    check_eq("bp_nwr", wr_cnt - wb, 1);
    check_eq("bp_wdata", wr_data_log[wb], core_fn(64'hCAFE_F00D_1234_5678));

    // Zero count
    mb = men_cnt; db = done_cnt;
    pulse_start(6'd3, 6'd4, 7'd0);
    wait_done("zero", 2, cyc);
    @(negedge clk);
    check_eq("zero_ndone", done_cnt - db, 1);
    check_eq("zero_no_mem", men_cnt - mb, 0);

    // Reset during WAIT_RES of block 2 of 5
    mem_load(6'd41, 64'h5E57_1E15_5E57_1E15);
    core_lat = 6;
    wb = wr_cnt; ab = acc_cnt;
    pulse_start(6'd10, 6'd40, 7'd5);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (acc_cnt - ab == 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("mid_reach_blk2", ok, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid");
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("mid_nwr", wr_cnt - wb, 1);
    check_eq("mid_no_resume", busy, 0);
    check_eq("mid_mem41", mem[41], 64'h5E57_1E15_5E57_1E15);
    core_lat = 2;
    mem_load(6'd10, 64'h0102_0304_0506_0708);
    pulse_start(6'd10, 6'd50, 7'd1);
    wait_done("after_rst", 50, cyc);
    check_eq("after_rst_mem50", mem[50], core_fn(64'h0102_0304_0506_0708));

    // Start while busy
    wb = wr_cnt; db = done_cnt;
    pulse_start(6'd20, 6'd30, 7'd3);
    repeat (2) @(negedge clk);
    pulse_start(6'd0, 6'd0, 7'd5);
    wait_done("sb", 200, cyc);
    repeat (20) @(negedge clk);
    check_eq("sb_nwr", wr_cnt - wb, 3);
    check_eq("sb_ndone", done_cnt - db, 1);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("sb_wa%0d", i), wr_addr_log[wb + i], 6'd30 + 6'(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_mem_sequencer.md
DES_MEM_SEQUENCER -- requirements
Module: des_mem_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_W, 6, memory address width; DATA_W, 64, DES block width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-003 SHALL have ports (name direction width meaning):
- clk input 1 clock
- rst input 1 asynchronous active-low reset
- start input 1 one-cycle job start pulse
- src_base input ADDR_W first source block address
- dst_base input ADDR_W first destination block address
- num_blocks input ADDR_W+1 block count, 0..64
- busy output 1 job in progress
- done output 1 one-cycle completion pulse
- mem_en output 1 memory enable
- rd_wr output 1 port-0 write strobe, active-low; always 1 (read)
- rd_add output ADDR_W port-0 read address
- rd_data input DATA_W port-0 read data, valid one cycle after the address is presented with mem_en=1
- wr_wr output 1 port-1 write strobe, active-low
- wr_add output ADDR_W port-1 write address
- wr_data output DATA_W port-1 write data
- core_in_valid output 1 block offered to DES core
- core_in_ready input 1 DES core accepts block
- core_in_data output DATA_W block to DES core
- core_out_valid input 1 one-cycle result pulse from DES core
- core_out_data input DATA_W result block

Function
REQ-004 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, SEND, WAIT_RES, WRITE, DONE.
REQ-005 IDLE: on start=1, SHALL latch src_base, dst_base and num_blocks, clear the block counter, and go to RD_REQ; if the latched num_blocks=0, SHALL go to DONE instead.
REQ-006 RD_REQ: SHALL drive rd_add = src_base + count (mod 2^ADDR_W), then go to RD_WAIT.
REQ-007 RD_WAIT: SHALL capture rd_data into a DATA_W block register, then go to SEND.
REQ-008 SEND: SHALL assert core_in_valid with core_in_data = block register; core_in_data SHALL be held stable until core_in_ready=1; on core_in_valid & core_in_ready, SHALL go to WAIT_RES.
REQ-009 WAIT_RES: on core_out_valid=1, SHALL capture core_out_data into a result register and go to WRITE; there is no timeout.
REQ-010 WRITE: SHALL drive wr_wr=0 for exactly one cycle with wr_add = dst_base + count (mod 2^ADDR_W) and wr_data = result register, then increment count.
REQ-011 After WRITE: if count+1 = num_blocks, SHALL go to DONE; otherwise SHALL go to RD_REQ.
REQ-012 DONE: SHALL assert done=1 for one cycle, then return to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-014 mem_en SHALL be 1 in RD_REQ, RD_WAIT and WRITE, and 0 otherwise.
REQ-015 wr_wr SHALL be 1 in every state except WRITE; rd_wr SHALL be constant 1.
REQ-016 Address arithmetic SHALL wrap modulo 64 (e.g. src_base=62 with 4 blocks reads 62, 63, 0, 1).
REQ-017 core_out_valid outside WAIT_RES SHALL be ignored.
REQ-018 Overlapping source and destination ranges SHALL be allowed; each block is read before it is written, so in-place processing with src_base = dst_base is correct.
REQ-019 Per-block latency SHALL be 5 cycles plus the core handshake wait plus the core result wait.

Reset
REQ-020 On rst=0, SHALL immediately enter IDLE and clear count, block register and result register.
REQ-021 During reset: busy=0, done=0, mem_en=0, rd_wr=1, wr_wr=1, core_in_valid=0; all addresses and data outputs SHALL be 0.
REQ-022 Reset asserted mid-job SHALL abort the job with no further memory write; the job SHALL NOT resume after reset release.

Verification
REQ-023 Single block: start, src_base=0, dst_base=32, num_blocks=1, mem[0]=0x0123456789ABCDEF, core returns 0x85E813540F0AB405 -> one write of that value to address 32, then a done pulse.
REQ-024 Wrap: src_base=62, dst_base=62, num_blocks=4 -> reads 62, 63, 0, 1 in order; writes to the same addresses; exactly 4 writes.
REQ-025 Backpressure: core_in_ready held 0 for 10 cycles -> core_in_valid stays 1, core_in_data stable, no memory access during the stall.
REQ-026 Zero count: num_blocks=0 -> done pulses 2 cycles after start; mem_en never asserts.
REQ-027 Reset mid-job: rst=0 during WAIT_RES of block 2 of 5 -> outputs return to REQ-021 values, no write to dst_base+1, and start is accepted after release.
REQ-028 Start while busy: a second start pulse during a job -> ignored; exactly num_blocks writes and a single done pulse.
